// File: rtl/tpu_result_drain_pkg.sv
// Shared sizing defaults and drain FSM state encoding for the TPU result reader.
package tpu_pkg;

  localparam int unsigned ADDRESSSIZE    = 10;
  localparam int unsigned PARTIAL_SUM_BW = 20;
  localparam int unsigned MATRIX_SIZE    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/tpu_result_drain_if.sv
// Host-facing result stream: one row per beat, valid/ready handshake.
interface tpu_result_drain_if #(
  parameter int unsigned W = tpu_pkg::PARTIAL_SUM_BW * tpu_pkg::MATRIX_SIZE
) ();

  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [W-1:0] m_data;

  modport master (output m_valid, output m_data, output m_last, input  m_ready);
  modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);

endinterface

// File: rtl/tpu_result_drain_rd_skid_buffer.sv
// Two-entry FIFO absorbing SRAM read data while the host stalls.
module rd_skid_buffer #(
  parameter int unsigned W = 160
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  import tpu_pkg::*;

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (count_q != 2'd0);
    // A push into a full buffer is only accepted when the head leaves this cycle.
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/tpu_result_drain.sv
// Reads a block of result rows from the 1-cycle-latency result SRAM and streams them
// to the host, optionally undoing the writer's lane reversal.
module tpu_result_drain #(
  parameter int unsigned ADDRESSSIZE    = tpu_pkg::ADDRESSSIZE,
  parameter int unsigned PARTIAL_SUM_BW = tpu_pkg::PARTIAL_SUM_BW,
  parameter int unsigned MATRIX_SIZE    = tpu_pkg::MATRIX_SIZE,
  parameter int unsigned UNREVERSE      = 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [ADDRESSSIZE-1:0]                base_addr,
  input  logic [ADDRESSSIZE-1:0]                row_count,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  valid_address,
  output logic                                  rd_en,
  output logic [ADDRESSSIZE-1:0]                rd_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] rd_data,
  tpu_result_drain_if.master                    m
);
  import tpu_pkg::*;

  localparam int unsigned W = PARTIAL_SUM_BW * MATRIX_SIZE;

  drain_state_e           state_q, state_d;
  logic [ADDRESSSIZE-1:0] addr_q, addr_d;
  logic [ADDRESSSIZE-1:0] rows_q, rows_d;
  logic [ADDRESSSIZE-1:0] issued_q, issued_d;
  logic [ADDRESSSIZE-1:0] beats_q, beats_d;
  logic                   inflight_q, inflight_d;

  logic                   rd_en_c;
  logic                   pop;
  logic                   last_beat;
  logic [W-1:0]           buf_data;
  logic [W-1:0]           lane_data;
  logic [1:0]             buf_count;
  logic                   buf_full;
  logic                   buf_empty;

  rd_skid_buffer #(.W(W)) u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight_q),
    .pop   (pop),
    .wdata (rd_data),
    .rdata (buf_data),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign pop       = !buf_empty && m.m_ready;
  assign last_beat = (beats_q == rows_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rows_d     = rows_q;
    issued_d   = issued_q;
    beats_d    = beats_q;
    rd_en_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          rows_d   = row_count;
          issued_d = '0;
          beats_d  = '0;
          state_d  = (row_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        // Buffered rows plus the read in flight must stay within the two buffer slots.
        rd_en_c = (!buf_full && !(inflight_q && (buf_count != 2'd0))) || pop;
        if (rd_en_c) begin
          addr_d   = addr_q + 1'b1;
          issued_d = issued_q + 1'b1;
          if (issued_q == rows_q - 1'b1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && last_beat) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (pop) begin
      beats_d = beats_q + 1'b1;
    end
    inflight_d = rd_en_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rows_q     <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rows_q     <= rows_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    lane_data = '0;
    for (int unsigned i = 0; i < MATRIX_SIZE; i++) begin
      if (UNREVERSE != 0) begin
        lane_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
          buf_data[(MATRIX_SIZE-1-i)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
      end else begin
        lane_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
          buf_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign valid_address = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign rd_en         = rd_en_c;
  assign rd_addr       = addr_q;
  assign m.m_valid     = !buf_empty;
  assign m.m_last      = !buf_empty && last_beat;
  assign m.m_data      = lane_data;

endmodule

// File: tb/tb_tpu_result_drain.sv
// Randomized bench for tpu_result_drain: two instances (UNREVERSE=1 and 0) share stimulus
// and are compared every cycle against a transfer-level model of the drain.
module tb_tpu_result_drain;
  import tpu_pkg::*;

  localparam int unsigned P     = PARTIAL_SUM_BW;
  localparam int unsigned M     = MATRIX_SIZE;
  localparam int unsigned W     = P * M;
  localparam int unsigned DEPTH = 1 << ADDRESSSIZE;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   start = 1'b0;
  logic [ADDRESSSIZE-1:0] base_addr = '0;
  logic [ADDRESSSIZE-1:0] row_count = '0;
  logic                   m_ready = 1'b0;

  logic [1:0]             busy_w, done_w, va_w, rd_en_w, mv_w, ml_w;
  logic [ADDRESSSIZE-1:0] rd_addr_w [2];
  logic [W-1:0]           rd_data_w [2];
  logic [W-1:0]           md_w [2];
  logic [W-1:0]           sram [DEPTH];

  tpu_result_drain_if #(.W(W)) if_rev ();
  tpu_result_drain_if #(.W(W)) if_pass ();

  assign if_rev.m_ready  = m_ready;
  assign if_pass.m_ready = m_ready;
  assign mv_w[0] = if_rev.m_valid;
  assign mv_w[1] = if_pass.m_valid;
  assign ml_w[0] = if_rev.m_last;
  assign ml_w[1] = if_pass.m_last;
  assign md_w[0] = if_rev.m_data;
  assign md_w[1] = if_pass.m_data;

  tpu_result_drain #(.UNREVERSE(1)) u_dut_rev (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .row_count(row_count),
    .busy(busy_w[0]), .done(done_w[0]), .valid_address(va_w[0]), .rd_en(rd_en_w[0]),
    .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]), .m(if_rev)
  );

  tpu_result_drain #(.UNREVERSE(0)) u_dut_pass (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .row_count(row_count),
    .busy(busy_w[1]), .done(done_w[1]), .valid_address(va_w[1]), .rd_en(rd_en_w[1]),
    .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]), .m(if_pass)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en_w[i]) rd_data_w[i] <= sram[rd_addr_w[i]];
    end
  end

  int checks = 0;
  int errors = 0;

  // Transfer-level model state and per-transfer records
  int ph = 0;
  int unsigned m_base = 0, m_cnt = 0, reads = 0, beats = 0;
  int cyc = 0, accept_cyc = 0, first_valid_cyc = -1, first_rd_cyc = -1;
  int first_pop_cyc = 0, last_pop_cyc = 0, done_cyc = 0;
  int unsigned first_rd_addr = 0, last_rd_addr = 0;
  int n_rd = 0, n_pop = 0, n_done = 0, n_busy = 0, n_valid = 0;
  logic [W-1:0] first_d0 = '0, first_d1 = '0, last_d1 = '0;
  bit pop;

  int rdy_mode = 0;
  int pidx = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_row(input int unsigned addr, input bit rev);
    logic [W-1:0] r;
    logic [W-1:0] o;
    r = sram[addr % DEPTH];
    o = '0;
    for (int unsigned j = 0; j < M; j++)
      o[j*P +: P] = rev ? r[(M-1-j)*P +: P] : r[j*P +: P];
    return o;
  endfunction

  function automatic int unsigned lane(input logic [W-1:0] d, input int unsigned j);
    return int'(d[j*P +: P]);
  endfunction

  task automatic kick(input int unsigned b, input int unsigned c, input bit twice);
    @(posedge clk); #1;
    base_addr = b[ADDRESSSIZE-1:0];
    row_count = c[ADDRESSSIZE-1:0];
    start = 1'b1;
    if (twice) begin
      @(posedge clk); #1;
      base_addr = base_addr + 10'd3;
      row_count = 10'd5;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned bound, input string name);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy_w[0]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, bound);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int p0, d0, r0, v0, b0;
    bit seen;

    for (int unsigned k = 0; k < DEPTH; k++)
      for (int unsigned j = 0; j < M; j++)
        sram[k][j*P +: P] = (k < 64 || k >= DEPTH - 4) ? P'(k*16 + j) : P'($urandom);

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!rstn) begin
          chk("rst_busy", busy_w, 0);
          chk("rst_done", done_w, 0);
          chk("rst_valid_address", va_w, 0);
          chk("rst_rd_en", rd_en_w, 0);
          chk("rst_m_valid", mv_w, 0);
          chk("rst_m_last", ml_w, 0);
          chk("rst_rd_addr", rd_addr_w[0], 0);
          chk("rst_m_data", md_w[0], 0);
          ph = 0;
          continue;
        end
        pop = mv_w[0] && m_ready;
        chk("busy", busy_w, {2{ph != 0}});
        chk("done", done_w, {2{ph == 2}});
        chk("valid_address", va_w, {2{ph != 0}});
        chk("m_valid_pair", mv_w[1], mv_w[0]);
        chk("rd_en_pair", rd_en_w[1], rd_en_w[0]);
        if (ph != 1) begin
          chk("idle_rd_en", rd_en_w[0], 0);
          chk("idle_m_valid", mv_w[0], 0);
        end
        if (mv_w[0]) begin
          if (beats < m_cnt) begin
            chk("m_data_rev", md_w[0], exp_row(m_base + beats, 1'b1));
            chk("m_data_pass", md_w[1], exp_row(m_base + beats, 1'b0));
            chk("m_last", ml_w, {2{beats == m_cnt - 1}});
          end else begin
            chk("beat_overrun", beats, m_cnt - 1);
          end
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
          chk("m_last_no_valid", ml_w, 0);
        end
        if (rd_en_w[0]) begin
          chk("rd_within_count", reads < m_cnt, 1);
          chk("rd_addr_rev", rd_addr_w[0], (m_base + reads) % DEPTH);
          chk("rd_addr_pass", rd_addr_w[1], (m_base + reads) % DEPTH);
          chk("rd_no_overflow", ((reads - beats) < 2) || pop, 1);
          if (first_rd_cyc < 0) begin
            first_rd_cyc = cyc;
            first_rd_addr = rd_addr_w[0];
          end
          last_rd_addr = rd_addr_w[0];
          n_rd++;
          reads++;
        end
        if (pop) begin
          if (beats == 0) begin
            first_pop_cyc = cyc;
            first_d0 = md_w[0];
            first_d1 = md_w[1];
          end
          if (beats == m_cnt - 1) last_d1 = md_w[1];
          last_pop_cyc = cyc;
          beats++;
          n_pop++;
        end
        if (done_w[0]) begin
          n_done++;
          done_cyc = cyc;
        end
        if (busy_w[0]) n_busy++;
        if (mv_w[0]) n_valid++;
        case (ph)
          2: ph = 0;
          1: if (pop && beats == m_cnt) ph = 2;
          default: begin
            if (start) begin
              m_base = base_addr;
              m_cnt = row_count;
              reads = 0;
              beats = 0;
              ph = (row_count == 0) ? 2 : 1;
              accept_cyc = cyc + 1;
              first_valid_cyc = -1;
              first_rd_cyc = -1;
            end
          end
        endcase
      end
      forever begin
        @(posedge clk); #1;
        case (rdy_mode)
          0: m_ready = 1'b1;
          1: begin
            m_ready = pat[pidx];
            pidx = (pidx + 1) % 6;
          end
          2: m_ready = ($urandom % 3) != 0;
          default: m_ready = 1'b0;
        endcase
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Four rows from address 0, host always ready
    rdy_mode = 0;
    kick(0, 4, 1'b0);
    wait_idle(100, "t1");
    chk("t1_first_rd_latency", first_rd_cyc - accept_cyc, 0);
    chk("t1_first_valid_latency", first_valid_cyc - accept_cyc, 2);
    chk("t1_back_to_back", last_pop_cyc - first_pop_cyc, 3);
    chk("t1_done_after_last", done_cyc - last_pop_cyc, 1);
    chk("t1_rev_lane0", lane(first_d0, 0), 7);
    chk("t1_rev_lane7", lane(first_d0, 7), 0);
    chk("t1_pass_lane0", lane(first_d1, 0), 0);
    chk("t1_pass_lane7", lane(first_d1, 7), 7);
    chk("t1_pass_last_lane5", lane(last_d1, 5), 53);

    // Stalling host plus an ignored start while busy
    p0 = n_pop;
    rdy_mode = 1;
    pidx = 0;
    kick(10, 6, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    base_addr = 10'd500;
    row_count = 10'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(100, "t3");
    chk("t3_beats", n_pop - p0, 6);

    // Address wrap at the top of the SRAM
    rdy_mode = 0;
    kick(1022, 4, 1'b0);
    wait_idle(100, "t4");
    chk("t4_first_addr", first_rd_addr, 1022);
    chk("t4_last_addr", last_rd_addr, 1);

    // Empty transfer; second start during DONE is ignored
    d0 = n_done; r0 = n_rd; v0 = n_valid; b0 = n_busy;
    kick(7, 0, 1'b1);
    wait_idle(20, "t5");
    chk("t5_done_pulses", n_done - d0, 1);
    chk("t5_busy_cycles", n_busy - b0, 1);
    chk("t5_no_reads", n_rd - r0, 0);
    chk("t5_no_beats", n_valid - v0, 0);

    // Reset while one beat is buffered and the host is stalled
    rdy_mode = 3;
    d0 = n_done;
    kick(20, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mv_w[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_beat_buffered", seen, 1);
    chk("t6_busy_before_reset", busy_w[0], 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_no_done_on_abort", n_done - d0, 0);
    rdy_mode = 2;
    p0 = n_pop;
    kick(100, 5, 1'b0);
    wait_idle(200, "t6_restart");
    chk("t6_restart_beats", n_pop - p0, 5);

    // Random transfers
    for (int t = 0; t < 25; t++) begin
      int unsigned rb, rc;
      rdy_mode = int'($urandom % 3);
      rb = $urandom % DEPTH;
      rc = $urandom % 13;
      p0 = n_pop;
      kick(rb, rc, 1'b0);
      wait_idle(300, "rand");
      chk("rand_beats", n_pop - p0, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
